register_file_ext: RTL



---
 rtl/register_file_ext_if.sv | 25 ++
 rtl/register_file_ext.sv | 113 +++++++++++
 2 files changed

// File: rtl/register_file_ext_if.sv
// Bus between the core datapath and the register file: one write port,
// two combinational read ports, and the init/error status flags.
interface register_file_ext_if #(
    parameter int XLEN = 32
);
    logic            phase_writeback;
    logic [4:0]      rdsel;
    logic [XLEN-1:0] rddata;
    logic [4:0]      rs1sel;
    logic [4:0]      rs2sel;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic            init_done;
    logic            reg_err;

    modport master (
        output phase_writeback, rdsel, rddata, rs1sel, rs2sel,
        input  rs1data, rs2data, init_done, reg_err
    );

    modport slave (
        input  phase_writeback, rdsel, rddata, rs1sel, rs2sel,
        output rs1data, rs2data, init_done, reg_err
    );
endinterface

// File: rtl/register_file_ext.sv
// RV32I/RV32E register file with post-reset clearing sequencer, optional
// writeback-to-read bypass and sticky out-of-range select detection.
module register_file_ext #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    register_file_ext_if.slave bus
);
    localparam int            IW       = $clog2(NREG);
    localparam logic [5:0]    NREG_LIM = 6'(NREG);
    localparam logic [IW-1:0] LAST     = IW'(NREG - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   cidx;
    logic [XLEN-1:0] regs [NREG];
    logic            ready;
    logic            clearing;
    logic            rd_in, rs1_in, rs2_in;
    logic            rd_ok, rs1_ok, rs2_ok;
    logic            wr_en;
    logic            err_hit;
    logic [IW-1:0]   rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0] rs1_val, rs2_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (cidx == LAST) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        ready    = (state == READY);
        clearing = (state == CLEAR);
    end

    // Range checks are done on a widened select so nothing above NREG aliases
    // onto a low register once the select is truncated to an array index.
    always_comb begin
        rd_in   = ({1'b0, bus.rdsel}  < NREG_LIM);
        rs1_in  = ({1'b0, bus.rs1sel} < NREG_LIM);
        rs2_in  = ({1'b0, bus.rs2sel} < NREG_LIM);
        rd_ok   = rd_in  && (bus.rdsel  != 5'd0);
        rs1_ok  = rs1_in && (bus.rs1sel != 5'd0);
        rs2_ok  = rs2_in && (bus.rs2sel != 5'd0);
        rd_idx  = bus.rdsel[IW-1:0];
        rs1_idx = bus.rs1sel[IW-1:0];
        rs2_idx = bus.rs2sel[IW-1:0];
        wr_en   = ready && !rst && bus.phase_writeback && rd_ok;
        err_hit = !rs1_in || !rs2_in || (bus.phase_writeback && !rd_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cidx <= IW'(1);
        end else if (clearing) begin
            cidx <= cidx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clearing && !rst) begin
            regs[cidx] <= '0;
        end else if (wr_en) begin
            regs[rd_idx] <= bus.rddata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.reg_err <= 1'b0;
        end else if (ready && err_hit) begin
            bus.reg_err <= 1'b1;
        end
    end

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (ready) begin
            if (BYPASS && bus.phase_writeback && rd_ok && (bus.rdsel == bus.rs1sel)) begin
                rs1_val = bus.rddata;
            end else if (rs1_ok) begin
                rs1_val = regs[rs1_idx];
            end
            if (BYPASS && bus.phase_writeback && rd_ok && (bus.rdsel == bus.rs2sel)) begin
                rs2_val = bus.rddata;
            end else if (rs2_ok) begin
                rs2_val = regs[rs2_idx];
            end
        end
    end

    assign bus.rs1data   = rs1_val;
    assign bus.rs2data   = rs2_val;
    assign bus.init_done = ready;
endmodule
